// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: builds signed decimal operands, issues one
// add/sub/mul to a shared arithmetic unit over start/done, and handles timeout/overflow.
module calc_sequencer #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       key_digit,
  input  logic             key_valid,
  input  logic             neg_valid,
  input  logic [1:0]       op_sel,
  input  logic             op_valid,
  input  logic             eq_valid,
  input  logic             clr_valid,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [1:0]       au_op,
  output logic             au_start,
  input  logic             au_done,
  input  logic [WIDTH-1:0] au_result,
  input  logic             au_ovf,
  output logic [WIDTH-1:0] display,
  output logic             complete,
  output logic             error,
  output logic             busy
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH+3:0] MAXPOS = {5'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {ENTER_A, ENTER_B, ISSUE, WAIT, DONE, ERROR} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag, reg_a, res;
  logic             sign;
  logic [CW-1:0]    cnt;
  logic [1:0]       op;
  logic [TW-1:0]    tmo;

  logic [WIDTH+3:0] mag_ext, mag_next;
  logic             dig_ok;
  logic [WIDTH-1:0] ent_val;

  // mag*10 + digit, widened so the range check sees any overflow past WIDTH
  always_comb begin
    mag_ext  = {4'b0, mag};
    mag_next = (mag_ext << 3) + (mag_ext << 1) + {{WIDTH{1'b0}}, key_digit};
    dig_ok   = (key_digit <= 4'd9) && (cnt < CW'(MAX_DIGITS)) && (mag_next <= MAXPOS);
    ent_val  = sign ? -mag : mag;
  end

  always_comb begin
    display = ent_val;
    case (state)
      DONE:    display = res;
      ERROR:   display = '0;
      default: display = ent_val;
    endcase
  end

  assign busy = (state == ISSUE) || (state == WAIT);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= ENTER_A; mag <= '0; reg_a <= '0; res <= '0; sign <= 1'b0; cnt <= '0;
      op <= '0; tmo <= '0; au_a <= '0; au_b <= '0; au_op <= '0; au_start <= 1'b0;
      complete <= 1'b0; error <= 1'b0;
    end else if (clr_valid) begin
      state <= ENTER_A; mag <= '0; reg_a <= '0; res <= '0; sign <= 1'b0; cnt <= '0;
      op <= '0; tmo <= '0; au_a <= '0; au_b <= '0; au_op <= '0; au_start <= 1'b0;
      complete <= 1'b0; error <= 1'b0;
    end else begin
      case (state)
        ENTER_A, ENTER_B: begin
          // strobes are prioritised even when the winner turns out to be a no-op
          if (eq_valid) begin
            if (state == ENTER_B && cnt != '0) begin
              au_a <= reg_a; au_b <= ent_val; au_op <= op; au_start <= 1'b1;
              state <= ISSUE;
            end
          end else if (op_valid) begin
            if (op_sel != 2'b11) begin
              if (state == ENTER_A) begin
                reg_a <= ent_val; op <= op_sel;
                mag <= '0; sign <= 1'b0; cnt <= '0;
                state <= ENTER_B;
              end else if (cnt == '0) begin
                op <= op_sel;
              end
            end
          end else if (neg_valid) begin
            sign <= ~sign;
          end else if (key_valid && dig_ok) begin
            mag <= mag_next[WIDTH-1:0];
            cnt <= cnt + 1'b1;
          end
        end
        ISSUE: begin
          au_start <= 1'b0;
          tmo      <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (au_done) begin
            if (au_ovf) begin
              error <= 1'b1; state <= ERROR;
            end else begin
              res <= au_result; complete <= 1'b1; state <= DONE;
            end
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            error <= 1'b1; state <= ERROR;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DONE: begin
          if (eq_valid) begin
            // equals on a shown result does nothing
          end else if (op_valid) begin
            if (op_sel != 2'b11) begin
              reg_a <= res; op <= op_sel; complete <= 1'b0;
              mag <= '0; sign <= 1'b0; cnt <= '0;
              state <= ENTER_B;
            end
          end else if (neg_valid) begin
            if (res == MINNEG) begin
              complete <= 1'b0; error <= 1'b1; state <= ERROR;
            end else begin
              res <= -res; reg_a <= -res;
            end
          end else if (key_valid && key_digit <= 4'd9) begin
            complete <= 1'b0;
            mag <= {{(WIDTH-4){1'b0}}, key_digit}; sign <= 1'b0; cnt <= CW'(1);
            state <= ENTER_A;
          end
        end
        ERROR: begin
          complete <= 1'b0;
        end
        default: state <= ENTER_A;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: keypad sequences, AU handshake, errors, clear and reset.
module tb_calc_sequencer;
  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [3:0]  key_digit = '0;
  logic        key_valid = 1'b0, neg_valid = 1'b0, op_valid = 1'b0, eq_valid = 1'b0, clr_valid = 1'b0;
  logic [1:0]  op_sel = '0;
  logic [15:0] au_a, au_b, au_result = '0, display;
  logic [1:0]  au_op;
  logic        au_start, au_done = 1'b0, au_ovf = 1'b0, complete, error, busy;
  int checks = 0, failures = 0;

  calc_sequencer dut (
    .clk(clk), .nRST(nRST), .key_digit(key_digit), .key_valid(key_valid),
    .neg_valid(neg_valid), .op_sel(op_sel), .op_valid(op_valid), .eq_valid(eq_valid),
    .clr_valid(clr_valid), .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_start(au_start),
    .au_done(au_done), .au_result(au_result), .au_ovf(au_ovf), .display(display),
    .complete(complete), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic digit(input logic [3:0] d);
    key_digit = d; key_valid = 1'b1; tick(); key_valid = 1'b0;
  endtask
  task automatic neg(); neg_valid = 1'b1; tick(); neg_valid = 1'b0; endtask
  task automatic op(input logic [1:0] s); op_sel = s; op_valid = 1'b1; tick(); op_valid = 1'b0; endtask
  task automatic eq(); eq_valid = 1'b1; tick(); eq_valid = 1'b0; endtask
  task automatic clr(); clr_valid = 1'b1; tick(); clr_valid = 1'b0; endtask

  // called right after eq(): ISSUE cycle, one WAIT cycle, then au_done
  task automatic au_reply(input logic [15:0] r, input logic ovf);
    chk("start_hi", au_start, 1);
    tick();
    chk("start_single", au_start, 0);
    chk("busy_wait", busy, 1);
    tick();
    au_done = 1'b1; au_result = r; au_ovf = ovf;
    tick();
    au_done = 1'b0; au_ovf = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_display", display, 0);
    chk("rst_complete", complete, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", au_start, 0);
    chk("rst_au_a", au_a, 0);
    #10 nRST = 1'b1;
    tick();

    // 123 + 45
    digit(1); digit(2); digit(3);
    chk("entry_123", display, 16'd123);
    op(2'b00);
    chk("b_empty", display, 0);
    digit(4); digit(5);
    chk("entry_45", display, 16'd45);
    eq();
    chk("t1_au_a", au_a, 16'd123);
    chk("t1_au_b", au_b, 16'd45);
    chk("t1_au_op", au_op, 2'b00);
    chk("t1_busy", busy, 1);
    au_reply(16'd168, 1'b0);
    chk("t1_display", display, 16'd168);
    chk("t1_complete", complete, 1);
    chk("t1_busy_done", busy, 0);

    // -7 - 9, then chain *2
    digit(7);
    chk("t2_new_a", display, 16'd7);
    chk("t2_complete_clr", complete, 0);
    neg();
    chk("t2_neg", display, 16'hFFF9);
    op(2'b01); digit(9); eq();
    chk("t2_au_a", au_a, 16'hFFF9);
    chk("t2_au_b", au_b, 16'd9);
    chk("t2_au_op", au_op, 2'b01);
    au_reply(16'hFFF0, 1'b0);
    chk("t2_display", display, 16'hFFF0);
    chk("t2_complete", complete, 1);
    op(2'b10);
    chk("chain_complete", complete, 0);
    digit(2); eq();
    chk("chain_au_a", au_a, 16'hFFF0);
    chk("chain_au_b", au_b, 16'd2);
    chk("chain_au_op", au_op, 2'b10);
    au_reply(16'hFFE0, 1'b0);
    chk("chain_display", display, 16'hFFE0);
    neg();
    chk("done_neg", display, 16'h0020);
    chk("done_neg_complete", complete, 1);

    // digit limits
    clr();
    chk("clr_display", display, 0);
    digit(3); digit(2); digit(7); digit(6); digit(7);
    chk("max_32767", display, 16'd32767);
    digit(1);
    chk("sixth_rejected", display, 16'd32767);
    clr();
    digit(4'd10);
    chk("digit10_rejected", display, 0);
    digit(3); digit(2); digit(7); digit(6); digit(8);
    chk("range_rejected", display, 16'd3276);
    neg(); neg();
    chk("neg_twice", display, 16'd3276);

    // timeout
    clr();
    digit(1); op(2'b00); digit(1); eq();
    tick();
    for (int i = 0; i < 63; i++) tick();
    chk("tmo_still_busy", busy, 1);
    chk("tmo_no_err_yet", error, 0);
    tick();
    chk("tmo_error", error, 1);
    chk("tmo_display", display, 0);
    chk("tmo_busy", busy, 0);
    digit(5);
    chk("err_ignores_digit", error, 1);
    clr();
    chk("tmo_clr_error", error, 0);
    chk("tmo_clr_display", display, 0);

    // overflow from AU
    digit(2); op(2'b10); digit(3); eq();
    au_reply(16'd6, 1'b1);
    chk("ovf_error", error, 1);
    chk("ovf_complete", complete, 0);
    chk("ovf_display", display, 0);
    clr();

    // negating most-negative result
    digit(1); op(2'b01); digit(1); eq();
    au_reply(16'h8000, 1'b0);
    chk("min_display", display, 16'h8000);
    neg();
    chk("min_neg_error", error, 1);
    chk("min_neg_complete", complete, 0);
    clr();

    // clear during WAIT, then a late au_done
    digit(2); op(2'b00); digit(2); eq();
    tick();
    chk("clrwait_busy", busy, 1);
    clr();
    au_done = 1'b1; au_result = 16'd4; tick(); au_done = 1'b0;
    chk("late_done_display", display, 0);
    chk("late_done_complete", complete, 0);
    chk("late_done_busy", busy, 0);
    chk("late_done_au_a", au_a, 0);

    // op and digit in the same cycle: op wins
    digit(2);
    key_digit = 4'd5; key_valid = 1'b1; op_sel = 2'b00; op_valid = 1'b1;
    tick();
    key_valid = 1'b0; op_valid = 1'b0;
    chk("prio_b_empty", display, 0);
    digit(1); eq();
    chk("prio_au_a", au_a, 16'd2);
    chk("prio_au_b", au_b, 16'd1);
    tick();
    chk("arst_pre_busy", busy, 1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_au_a", au_a, 0);
    chk("arst_au_b", au_b, 0);
    chk("arst_busy", busy, 0);
    chk("arst_display", display, 0);
    chk("arst_start", au_start, 0);
    #1 nRST = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
